// File: rtl/seqdet_pkg.sv
// Shared defaults and helpers for the programmable sequence detector.
//   DEF_PATTERN / DEF_LEN : configuration loaded at reset
//   LEN_W                 : length-field width for the default MAX_LEN
//   len_mask()            : low-len-bits compare mask (len up to MASK_W)
package seqdet_pkg;

  localparam int unsigned MAX_LEN_DEF = 8;
  localparam int unsigned LEN_W       = $clog2(MAX_LEN_DEF + 1);
  localparam int unsigned MASK_W      = 32;

  localparam logic [MAX_LEN_DEF-1:0] DEF_PATTERN = 8'b0000_1011;
  localparam int unsigned            DEF_LEN     = 4;

  // Ones in bits [len-1:0]; saturates to all-ones once len reaches MASK_W.
  function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
    if (len >= 32'(MASK_W)) return '1;
    return (MASK_W'(1) << len) - MASK_W'(1);
  endfunction

endpackage

// File: rtl/seqdet_if.sv
// Bus between a serial bit source/config master and the detector.
//   master : drives seq_in, in_valid, overlap_en, cfg_*, count_clr
//   slave  : drives det_out, det_count, cfg_err
interface seqdet_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned COUNT_W = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic               seq_in;
  logic               in_valid;
  logic               overlap_en;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               count_clr;
  logic               det_out;
  logic [COUNT_W-1:0] det_count;
  logic               cfg_err;

  modport master (
    output seq_in, in_valid, overlap_en, cfg_load, cfg_pattern, cfg_len, count_clr,
    input  det_out, det_count, cfg_err
  );

  modport slave (
    input  seq_in, in_valid, overlap_en, cfg_load, cfg_pattern, cfg_len, count_clr,
    output det_out, det_count, cfg_err
  );
endinterface

// File: rtl/seqdet_window.sv
// Combinational window compare: does {hist, seq_in} end in the len-bit
// pattern, with enough valid history (fill) to make the match real.
//   hist, seq_in    : held history and the incoming bit
//   pattern, len    : active configuration
//   fill            : number of valid bits in hist
//   match           : window matches (caller qualifies with bit acceptance)
module seqdet_window
  import seqdet_pkg::*;
#(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic               seq_in,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [LEN_W-1:0]   fill,
  output logic               match
);

  logic [MAX_LEN:0] window;
  logic [MAX_LEN:0] mask;
  logic             fill_ok;

  always_comb begin
    window  = {hist, seq_in};
    // Top window bit is never part of a pattern, so its mask bit stays clear.
    mask    = (MAX_LEN + 1)'(len_mask(32'(len)));
    fill_ok = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len};
    match   = fill_ok && (((window ^ {1'b0, pattern}) & mask) == '0);
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Run-time programmable serial pattern detector with registered detect
// pulse, saturating detection counter and config-reject pulse.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : serial input, config load, count clear, detect outputs
module seq_detector_prog #(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        COUNT_W     = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(seqdet_pkg::DEF_PATTERN),
  parameter int unsigned        DEF_LEN     = seqdet_pkg::DEF_LEN
) (
  input  logic     clk,
  input  logic     reset_n,
  seqdet_if.slave  bus
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic [MAX_LEN-1:0] hist,    hist_nxt;
  logic [LEN_W-1:0]   fill,    fill_nxt;
  logic [MAX_LEN-1:0] pattern, pattern_nxt;
  logic [LEN_W-1:0]   len,     len_nxt;
  logic [COUNT_W-1:0] count,   count_nxt;
  logic               det_q,   cfg_err_q, cfg_err_nxt;
  logic               win_match, hit_c, cfg_ok_c;

  seqdet_window #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_window (
    .hist    (hist),
    .seq_in  (bus.seq_in),
    .pattern (pattern),
    .len     (len),
    .fill    (fill),
    .match   (win_match)
  );

  // Next-state: config load wins over data; counter clear wins over increment.
  always_comb begin
    hist_nxt    = hist;
    fill_nxt    = fill;
    pattern_nxt = pattern;
    len_nxt     = len;
    count_nxt   = count;
    cfg_err_nxt = 1'b0;
    hit_c       = 1'b0;
    cfg_ok_c    = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(MAX_LEN));

    if (bus.cfg_load) begin
      if (cfg_ok_c) begin
        pattern_nxt = bus.cfg_pattern;
        len_nxt     = bus.cfg_len;
        fill_nxt    = '0;
      end else begin
        cfg_err_nxt = 1'b1;
      end
    end else if (bus.in_valid) begin
      hit_c    = win_match;
      hist_nxt = {hist[MAX_LEN-2:0], bus.seq_in};
      // Non-overlap restarts the fill so the next match needs len fresh bits.
      if (hit_c && !bus.overlap_en) fill_nxt = '0;
      else if (fill != LEN_W'(MAX_LEN)) fill_nxt = fill + LEN_W'(1);
    end

    if (bus.count_clr) count_nxt = '0;
    else if (hit_c && (count != '1)) count_nxt = count + COUNT_W'(1);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist      <= '0;
      fill      <= '0;
      pattern   <= DEF_PATTERN;
      len       <= LEN_W'(DEF_LEN);
      count     <= '0;
      det_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      pattern   <= pattern_nxt;
      len       <= len_nxt;
      count     <= count_nxt;
      det_q     <= hit_c;
      cfg_err_q <= cfg_err_nxt;
    end
  end

  assign bus.det_out   = det_q;
  assign bus.det_count = count;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
- Parametrised, run-time programmable serial bit-pattern detector; successor to the fixed 4-bit Moore detector.
- Pattern length 1..MAX_LEN and pattern value loaded through a config port. Overlapping or non-overlapping mode, selected live.
- Input qualified by a valid strobe. Registered detect pulse plus saturating detection counter.
- Sits between a serial bit source and status/interrupt logic.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- COUNT_W, 16, width of the detection counter.
- DEF_PATTERN, 8'b0000_1011, pattern loaded at reset (LSB-aligned, MAX_LEN bits).
- DEF_LEN, 4, pattern length loaded at reset.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- seq_in  in  1  serial data bit.
- in_valid  in  1  seq_in sampled only when high.
- overlap_en  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_load  in  1  load cfg_pattern/cfg_len this cycle.
- cfg_pattern  in  MAX_LEN  new pattern, LSB-aligned.
- cfg_len  in  $clog2(MAX_LEN+1)  new pattern length.
- count_clr  in  1  synchronous clear of det_count.
- det_out  out  1  one-cycle detect pulse (registered).
- det_count  out  COUNT_W  saturating number of detections.
- cfg_err  out  1  one-cycle pulse, rejected config.

Behaviour:
- Reset (reset_n low, async): history=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, det_out=0, det_count=0, cfg_err=0.
- Bit order: pattern[len-1] is the first bit received and pattern[0] is the last. Bits above len are ignored.
- State: shift history hist[MAX_LEN-1:0] plus fill counter 0..MAX_LEN (valid bits held).
- Accepted bit (in_valid=1, cfg_load=0):
  - window = {hist, seq_in}.
  - hist <= low MAX_LEN bits of window.
  - fill <= min(fill+1, MAX_LEN).
- match = accepted bit AND fill+1 >= len AND window[len-1:0] == pattern[len-1:0].
- det_out <= match. Latency: det_out high exactly the cycle after the edge that sampled the final pattern bit. No output while in_valid is low.
- Overlap mode: history is kept after a match.
- Non-overlap mode: on match, fill <= 0, so the next match needs len fresh bits. The hist contents do not matter because fill gates them.
- in_valid gaps: hist and fill hold. Detection is independent of gap length.
- Config load (cfg_load=1):
  - cfg_len in 1..MAX_LEN: latch pattern and length; fill <= 0; seq_in ignored that cycle; det_out <= 0.
  - Otherwise: config unchanged, fill unchanged, cfg_err <= 1 for one cycle, seq_in still ignored.
- det_count:
  - Increments on match and saturates at all-ones (no wrap).
  - count_clr has priority: count_clr with match in the same cycle gives det_count=0, but det_out still pulses.
- overlap_en change mid-stream: takes effect on the next accepted bit. No flush.
- reset_n asserted mid-sequence: the partial match is lost, and the next detection requires a full len bits after release.

Decomposition:
- Package seqdet_pkg holds:
  - DEF_PATTERN and DEF_LEN defaults.
  - Length-field width localparam, LEN_W = $clog2(MAX_LEN+1).
  - Helper function building the len-bit compare mask.
- Sub-module seqdet_window, purely combinational: inputs hist, seq_in, pattern, len, fill; output match.
- Top module holds the registers, config logic and counter.

Test Plan:
- Default 1011, overlap_en=1, stream 1,0,1,1,0,1,1 (in_valid=1) -> det_out pulses after bit 4 and after bit 7; det_count=2.
- Same stream, overlap_en=0 -> single pulse after bit 4; det_count=1.
- cfg_load pattern 8'hFF, len 8, overlap, then 10 consecutive 1s -> pulses after bits 8, 9, 10; det_count=3. Repeat with in_valid low for 3 cycles between bits 2 and 3 -> identical pulses relative to accepted bits.
- COUNT_W=2, default pattern, 5 matches -> det_count stays 3. count_clr asserted on a match cycle -> det_count=0, det_out=1.
- cfg_load with cfg_len=0, then cfg_len=MAX_LEN+1 (if representable) -> cfg_err pulses each time; 1011 still detected afterwards.
- Feed 1,0,1, then reset_n low for 1 cycle asynchronously mid-cycle, release, feed 1 -> no pulse and det_count=0. Then feed 1,0,1,1 -> one pulse.
